// File: rtl/sd_block_checker.sv
// Checks SD read data blocks (start token, payload, CRC16) streamed from the SPI read engine,
// counting good/bad blocks and the number of cycles the run spent busy.
module sd_block_checker #(
   parameter int BLOCK_BYTES    = 512,
   parameter int N_BLOCK_SIZE   = 32,
   parameter int CYCLE_CNT_SIZE = 32,
   parameter int TIMEOUT        = 65535
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [N_BLOCK_SIZE-1:0]   n_blocks,
   input  logic                      byte_valid,
   input  logic [7:0]                byte_in,
   output logic                      busy,
   output logic                      done,
   output logic [N_BLOCK_SIZE-1:0]   blocks_ok,
   output logic [N_BLOCK_SIZE-1:0]   block_errors,
   output logic                      timeout_err,
   output logic [CYCLE_CNT_SIZE-1:0] cycle_count,
   output logic [15:0]               last_crc
);

   localparam int BW = $clog2(BLOCK_BYTES);
   localparam int WW = $clog2(TIMEOUT + 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WAIT   = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_CRC_HI = 3'd3;
   localparam logic [2:0] S_CRC_LO = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   localparam logic [N_BLOCK_SIZE-1:0] BLK_ONE = {{(N_BLOCK_SIZE-1){1'b0}}, 1'b1};

   logic [2:0]              state;
   logic [N_BLOCK_SIZE-1:0] n_lat;
   logic [N_BLOCK_SIZE-1:0] blk_cnt;
   logic [BW-1:0]           byte_cnt;
   logic [WW-1:0]           wait_cnt;
   logic [15:0]             crc;
   logic [7:0]              crc_hi;
   logic [N_BLOCK_SIZE-1:0] blk_next;
   logic                    last_blk;

   // CRC16-CCITT, poly 0x1021, MSB first, one whole byte per call
   function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c ^ {d, 8'h00};
      for (int i = 0; i < 8; i++)
         r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      return r;
   endfunction

   assign busy     = (state == S_WAIT) || (state == S_DATA) ||
                     (state == S_CRC_HI) || (state == S_CRC_LO);
   assign done     = (state == S_DONE);
   assign blk_next = blk_cnt + BLK_ONE;
   assign last_blk = (blk_next == n_lat);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         n_lat        <= '0;
         blk_cnt      <= '0;
         byte_cnt     <= '0;
         wait_cnt     <= '0;
         crc          <= '0;
         crc_hi       <= '0;
         blocks_ok    <= '0;
         block_errors <= '0;
         timeout_err  <= 1'b0;
         cycle_count  <= '0;
         last_crc     <= '0;
      end else begin
         if (busy && cycle_count != '1)
            cycle_count <= cycle_count + 1'b1;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  n_lat        <= n_blocks;
                  blk_cnt      <= '0;
                  wait_cnt     <= '0;
                  blocks_ok    <= '0;
                  block_errors <= '0;
                  timeout_err  <= 1'b0;
                  cycle_count  <= '0;
                  last_crc     <= '0;
                  state        <= (n_blocks == '0) ? S_DONE : S_WAIT;
               end
            end
            S_WAIT: begin
               wait_cnt <= wait_cnt + 1'b1;
               // a token in the timeout cycle takes priority over the abort
               if (byte_valid && byte_in != 8'hFF) begin
                  if (byte_in == 8'hFE) begin
                     crc      <= '0;
                     byte_cnt <= '0;
                     state    <= S_DATA;
                  end else begin
                     block_errors <= block_errors + BLK_ONE;
                     blk_cnt      <= blk_next;
                     wait_cnt     <= '0;
                     state        <= last_blk ? S_DONE : S_WAIT;
                  end
               end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                  timeout_err <= 1'b1;
                  state       <= S_DONE;
               end
            end
            S_DATA: begin
               if (byte_valid) begin
                  crc      <= crc16_byte(crc, byte_in);
                  byte_cnt <= byte_cnt + 1'b1;
                  if (byte_cnt == BW'(BLOCK_BYTES - 1))
                     state <= S_CRC_HI;
               end
            end
            S_CRC_HI: begin
               if (byte_valid) begin
                  crc_hi <= byte_in;
                  state  <= S_CRC_LO;
               end
            end
            S_CRC_LO: begin
               if (byte_valid) begin
                  last_crc <= crc;
                  if ({crc_hi, byte_in} == crc)
                     blocks_ok <= blocks_ok + BLK_ONE;
                  else
                     block_errors <= block_errors + BLK_ONE;
                  blk_cnt  <= blk_next;
                  wait_cnt <= '0;
                  state    <= last_blk ? S_DONE : S_WAIT;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
